// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port, 1-cycle-latency word RAM.
// Data port has priority; a run counter forces an instruction grant after MAX_D_RUN data wins.
module ram_arbiter #(
  parameter int MAX_D_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [29:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [31:0] ram_dout
);

  // One-hot style encoding so each rvalid is a single flop bit.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_D_RUN);
  localparam logic [3:0] RUN_SAT   = 4'd15;

  logic [3:0] d_run_q, d_run_d;
  owner_e     owner_q, owner_d;
  logic       starve_s, d_gnt_s, i_gnt_s;

  // Arbitration and RAM control driven from the winner.
  always_comb begin
    starve_s = i_req & d_req & (d_run_q >= RUN_LIMIT);
    d_gnt_s  = d_req & ~starve_s;
    i_gnt_s  = i_req & ~d_gnt_s;
    ram_addr = 30'd0;
    ram_din  = 32'd0;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    if (d_gnt_s) begin
      ram_addr = d_addr;
      ram_din  = d_wdata;
      ram_we   = d_we;
      ram_re   = ~d_we;
    end else if (i_gnt_s) begin
      ram_addr = i_addr;
      ram_re   = 1'b1;
    end else begin
      ram_addr = 30'd0;
    end
  end

  // Next run count and next owner of the RAM read data.
  always_comb begin
    d_run_d = 4'd0;
    owner_d = OWN_NONE;
    if (d_gnt_s && i_req) begin
      d_run_d = (d_run_q == RUN_SAT) ? RUN_SAT : d_run_q + 4'd1;
    end else begin
      d_run_d = 4'd0;
    end
    if (d_gnt_s && !d_we) begin
      owner_d = OWN_D;
    end else if (i_gnt_s) begin
      owner_d = OWN_I;
    end else begin
      owner_d = OWN_NONE;
    end
  end

  // State registers; reset drops any outstanding read immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_run_q <= 4'd0;
      owner_q <= OWN_NONE;
    end else begin
      d_run_q <= d_run_d;
      owner_q <= owner_d;
    end
  end

  assign i_gnt    = i_gnt_s;
  assign d_gnt    = d_gnt_s;
  assign i_rvalid = owner_q[0];
  assign d_rvalid = owner_q[1];
  assign i_rdata  = ram_dout;
  assign d_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and a short randomised scoreboard phase.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [29:0] i_addr, d_addr;
  logic [31:0] d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0] i_rdata, d_rdata;
  logic [29:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_re, ram_we;

  logic [31:0] mem [0:63];
  logic [31:0] shadow [0:63];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.MAX_D_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_re(ram_re), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[5:0]] <= ram_din;
    if (ram_re) ram_dout <= mem[ram_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit exp_d, ei, ed, exp_i_rv, exp_d_rv;
    logic [31:0] exp_data;
    int m_run, i_wait;

    for (int a = 0; a < 64; a++) mem[a] = 32'hA000_0000 | 32'(a);
    mem[0] = 32'h0000_0010; mem[1] = 32'h0000_0011; mem[2] = 32'h0000_0012;
    mem[3] = 32'h0000_0033; mem[7] = 32'h0000_0077;
    ram_dout = 32'd0;

    // Reset with both requesters active.
    reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 30'd3; d_addr = 30'd7; d_wdata = 32'd0;
    tick();
    chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    tick();
    chk("rst_rvalid2", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);

    // Starvation guard: D,D,D,D,I repeating with both held.
    for (int k = 0; k < 10; k++) begin
      exp_d = (k % 5) != 4;
      #1;
      chk($sformatf("starve_gnt%0d", k), {30'd0, i_gnt, d_gnt}, exp_d ? 32'd1 : 32'd2);
      chk($sformatf("starve_addr%0d", k), {2'b00, ram_addr}, exp_d ? 32'd7 : 32'd3);
      tick();
      chk($sformatf("starve_rv%0d", k), {30'd0, i_rvalid, d_rvalid}, exp_d ? 32'd1 : 32'd2);
      chk($sformatf("starve_rd%0d", k), exp_d ? d_rdata : i_rdata,
          exp_d ? 32'h0000_0077 : 32'h0000_0033);
    end

    // Idle: everything to the RAM is zero.
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk("idle_gnt", {30'd0, i_gnt, d_gnt}, 32'd0);
    chk("idle_ram", {ram_addr, ram_re, ram_we}, 32'd0);
    chk("idle_din", ram_din, 32'd0);
    tick();
    chk("idle_rv", {30'd0, i_rvalid, d_rvalid}, 32'd0);

    // D write then I read of the same word.
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'd5; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    chk("wr_ram", {ram_addr, ram_re, ram_we}, {30'd5, 1'b0, 1'b1});
    chk("wr_din", ram_din, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 30'd5;
    chk("wr_no_rv", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    #1;
    chk("rd_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    chk("rd_ram", {ram_addr, ram_re, ram_we}, {30'd5, 1'b1, 1'b0});
    chk("rd_din", ram_din, 32'd0);
    tick();
    chk("rd_rv", {30'd0, i_rvalid, d_rvalid}, 32'd2);
    chk("rd_data", i_rdata, 32'hDEAD_BEEF);

    // I-only back-to-back reads, first issued in the previous rvalid cycle.
    for (int j = 0; j < 3; j++) begin
      i_addr = 30'(j);
      #1;
      chk($sformatf("b2b_gnt%0d", j), {31'd0, i_gnt}, 32'd1);
      tick();
      chk($sformatf("b2b_rv%0d", j), {31'd0, i_rvalid}, 32'd1);
      chk($sformatf("b2b_rd%0d", j), i_rdata, 32'h0000_0010 + 32'(j));
    end
    i_req = 1'b0;
    tick();

    // Reset asserted while a D read is outstanding.
    i_req = 1'b1; i_addr = 30'd3; d_req = 1'b1; d_addr = 30'd7;
    tick();
    chk("mid_rv_pre", {31'd0, d_rvalid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rv_drop", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("mid_gnt%0d", k), {30'd0, i_gnt, d_gnt}, (k == 4) ? 32'd2 : 32'd1);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Randomised traffic against a shadow memory and an arbitration model.
    for (int a = 0; a < 64; a++) begin
      mem[a] = 32'h5A00_0000 ^ 32'(a * 7);
      shadow[a] = 32'h5A00_0000 ^ 32'(a * 7);
    end
    exp_i_rv = 1'b0; exp_d_rv = 1'b0; exp_data = 32'd0;
    ei = 1'b0; ed = 1'b0; m_run = 0; i_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      chk("rnd_rv", {30'd0, i_rvalid, d_rvalid}, {30'd0, exp_i_rv, exp_d_rv});
      if (exp_i_rv) chk("rnd_irdata", i_rdata, exp_data);
      if (exp_d_rv) chk("rnd_drdata", d_rdata, exp_data);
      if (!i_req || ei) begin
        i_req = ($urandom_range(0, 9) < 6);
        i_addr = 30'($urandom_range(0, 15));
      end
      if (!d_req || ed) begin
        d_req = ($urandom_range(0, 9) < 7);
        d_addr = 30'($urandom_range(0, 15));
        d_we = $urandom_range(0, 1) == 1;
        d_wdata = $urandom;
      end
      #1;
      ed = d_req && !(i_req && d_req && m_run >= 4);
      ei = i_req && !ed;
      chk("rnd_gnt", {30'd0, i_gnt, d_gnt}, {30'd0, ei, ed});
      chk("rnd_excl", {30'd0, ram_re & ram_we, i_gnt & d_gnt}, 32'd0);
      if (i_req && !i_gnt) i_wait++; else i_wait = 0;
      chk("rnd_wait", {31'd0, i_wait > 4}, 32'd0);
      exp_i_rv = ei;
      exp_d_rv = ed && !d_we;
      exp_data = ei ? shadow[i_addr[5:0]] : shadow[d_addr[5:0]];
      if (ed && d_we) shadow[d_addr[5:0]] = d_wdata;
      m_run = (ed && i_req) ? ((m_run == 15) ? 15 : m_run + 1) : 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
